// File: rtl/lfsr_operand_sequencer.sv
// Purpose: samples an upstream LFSR into operand pairs (A then B) and buffers them in a small FIFO for a multiplier.
// Latency: a pair pushed in GRAB_B appears at the FIFO head the next cycle; done pulses one cycle after the FIFO drains.
// Backpressure: op_valid/op_ready handshake; when the FIFO is full the FSM holds A in GRAB_B and discards B samples.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   lfsr_in             current upstream LFSR value
//   start, num_pairs    run request (IDLE only) and number of pairs to produce
//   op_valid/op_ready   head-of-FIFO handshake; op_a/op_b are the head pair (0 when empty)
//   busy, done          run in progress / one-cycle completion pulse
//   lock_err            sticky: an all-zero LFSR value was consumed during the run
module lfsr_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lfsr_in,
    input  logic             start,
    input  logic [7:0]       num_pairs,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             lock_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRAB_A = 3'd1,
        GRAB_B = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_hold;
    logic [7:0]       target;
    logic [7:0]       pushed;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign fifo_empty = (count == '0);
    // Full is judged on the registered count, so a pop in the same cycle
    // never frees a slot for the push.
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign push       = (state == GRAB_B) && !fifo_full;
    assign pop        = !fifo_empty && op_ready;

    assign op_valid = !fifo_empty;
    assign op_a     = fifo_empty ? '0 : mem_a[rd_ptr];
    assign op_b     = fifo_empty ? '0 : mem_b[rd_ptr];

    // Storage has no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= a_hold;
            mem_b[wr_ptr] <= lfsr_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Control FSM; busy and done are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_hold   <= '0;
            target   <= '0;
            pushed   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target   <= num_pairs;
                        pushed   <= '0;
                        lock_err <= 1'b0;
                        busy     <= 1'b1;
                        if (num_pairs == 8'd0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= GRAB_A;
                        end
                    end
                end
                GRAB_A: begin
                    a_hold <= lfsr_in;
                    if (lfsr_in == '0) begin
                        lock_err <= 1'b1;
                    end
                    state <= GRAB_B;
                end
                GRAB_B: begin
                    // While full, stay here with A held; this B sample is dropped.
                    if (push) begin
                        pushed <= pushed + 8'd1;
                        if (lfsr_in == '0) begin
                            lock_err <= 1'b1;
                        end
                        if ((pushed + 8'd1) == target) begin
                            state <= DRAIN;
                        end else begin
                            state <= GRAB_A;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_operand_sequencer.sv
module tb_lfsr_operand_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int VW    = 2*WIDTH + 4;

    localparam int M_IDLE  = 0;
    localparam int M_A     = 1;
    localparam int M_B     = 2;
    localparam int M_DRAIN = 3;
    localparam int M_FIN   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] lfsr_in;
    logic             start;
    logic [7:0]       num_pairs;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             lock_err;

    always #5 clk = ~clk;

    lfsr_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .lfsr_in   (lfsr_in),
        .start     (start),
        .num_pairs (num_pairs),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .lock_err  (lock_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: run phase, queue of buffered pairs, held A sample.
    int                 m_state;
    logic [2*WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0]   m_a;
    int                 m_cnt;
    int                 m_n;
    logic               m_lock;

    logic [2*WIDTH-1:0] got_q[$];
    logic [2*WIDTH-1:0] pushed_q[$];
    int                 done_seen;

    task automatic model_reset();
        m_state = M_IDLE;
        m_q.delete();
        m_a     = '0;
        m_cnt   = 0;
        m_n     = 0;
        m_lock  = 1'b0;
    endtask

    task automatic clear_logs();
        got_q.delete();
        pushed_q.delete();
        done_seen = 0;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [2*WIDTH-1:0] h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        return {m_q.size() != 0, h, m_state != M_IDLE, m_state == M_FIN, m_lock};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {op_valid, op_a, op_b, busy, done, lock_err};
    endfunction

    // Advance one clock: update the model from the inputs as they stand before
    // the edge, then return at the following falling edge.
    task automatic step();
        bit do_push;
        bit do_pop;
        int pre_size;
        logic [2*WIDTH-1:0] tmp;
        if (op_valid && op_ready) got_q.push_back({op_a, op_b});
        pre_size = m_q.size();
        do_push  = (m_state == M_B) && (pre_size < DEPTH);
        do_pop   = (pre_size != 0) && op_ready;
        if (do_pop) tmp = m_q.pop_front();
        if (do_push) begin
            m_q.push_back({m_a, lfsr_in});
            pushed_q.push_back({m_a, lfsr_in});
        end
        case (m_state)
            M_IDLE: if (start) begin
                m_n     = int'(num_pairs);
                m_cnt   = 0;
                m_lock  = 1'b0;
                m_state = (num_pairs == 8'd0) ? M_FIN : M_A;
            end
            M_A: begin
                m_a = lfsr_in;
                if (lfsr_in == '0) m_lock = 1'b1;
                m_state = M_B;
            end
            M_B: if (do_push) begin
                m_cnt++;
                if (lfsr_in == '0) m_lock = 1'b1;
                m_state = (m_cnt == m_n) ? M_DRAIN : M_A;
            end
            M_DRAIN: if (pre_size == 0) m_state = M_FIN;
            default: m_state = M_IDLE;
        endcase
        @(posedge clk);
        @(negedge clk);
        if (done) done_seen++;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        start     = 1'b1;
        num_pairs = n;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_ready = 1'b0; num_pairs = '0; lfsr_in = '0;
        model_reset();
        clear_logs();
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs_vec() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] vals [4];
        vals = '{8'h01, 8'h02, 8'h04, 8'h08};
        clear_logs();
        op_ready = 1'b1;
        lfsr_in  = 8'hAA;
        pulse_start(8'd2);
        for (int i = 0; i < 4; i++) begin
            lfsr_in = vals[i];
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL basic_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        lfsr_in = 8'h55;
        for (int i = 0; i < 20 && m_state != M_IDLE; i++) begin
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL basic_tail%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (got_q.size() != 2 || got_q[0] !== 16'h0102 || got_q[1] !== 16'h0408) begin
            tests_failed++;
            $display("FAIL basic_pairs: got %0d pairs first %h second %h expected 0102 0408",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 16'h0, got_q.size() > 1 ? got_q[1] : 16'h0);
        end
        tests_run++;
        if (done_seen != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: done pulses %0d busy %b expected 1 pulse busy 0", done_seen, busy);
        end
    endtask

    task automatic test_zero();
        clear_logs();
        op_ready = 1'b1;
        pulse_start(8'd0);
        tests_run++;
        if ({busy, done, op_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL zero_first: got busy/done/valid %b expected 110", {busy, done, op_valid});
        end
        step();
        tests_run++;
        if ({busy, done, op_valid} !== 3'b000 || obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL zero_second: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_lock();
        clear_logs();
        op_ready = 1'b1;
        pulse_start(8'd1);
        lfsr_in = 8'h00;
        step();
        tests_run++;
        if (lock_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_set: got %b expected 1", lock_err);
        end
        lfsr_in = 8'h33;
        for (int i = 0; i < 20 && m_state != M_IDLE; i++) begin
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL lock_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (lock_err !== 1'b1 || done_seen != 1) begin
            tests_failed++;
            $display("FAIL lock_sticky: lock_err %b done pulses %0d expected 1 and 1", lock_err, done_seen);
        end
        lfsr_in = 8'h11;
        pulse_start(8'd1);
        tests_run++;
        if (lock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_clear: got %b expected 0", lock_err);
        end
        for (int i = 0; i < 20 && m_state != M_IDLE; i++) step();
    endtask

    task automatic test_backpressure();
        clear_logs();
        op_ready = 1'b0;
        pulse_start(8'd6);
        for (int i = 0; i < 20; i++) begin
            lfsr_in = WIDTH'($urandom_range(1, 255));
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (op_valid !== 1'b1 || busy !== 1'b1 || done_seen != 0 || pushed_q.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL bp_full: valid %b busy %b done %0d pushed %0d expected 1 1 0 %0d",
                     op_valid, busy, done_seen, pushed_q.size(), DEPTH);
        end
        op_ready = 1'b1;
        for (int i = 0; i < 60 && m_state != M_IDLE; i++) begin
            lfsr_in = WIDTH'($urandom_range(1, 255));
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL bp_drain%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (got_q.size() != 6 || got_q != pushed_q || done_seen != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_delivery: pairs %0d done %0d busy %b expected 6 in order, 1, 0",
                     got_q.size(), done_seen, busy);
        end
    endtask

    task automatic test_reset_midrun();
        clear_logs();
        op_ready = 1'b0;
        pulse_start(8'd5);
        for (int i = 0; i < 20 && m_q.size() < 2; i++) begin
            lfsr_in = WIDTH'($urandom_range(1, 255));
            step();
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || op_a !== '0 || op_b !== '0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: valid %b busy %b a %h b %h done %b expected all 0",
                     op_valid, busy, op_a, op_b, done);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        op_ready = 1'b1;
        pulse_start(8'd1);
        for (int i = 0; i < 20 && m_state != M_IDLE; i++) begin
            lfsr_in = WIDTH'($urandom_range(1, 255));
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL midrun_rerun%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (got_q.size() != 1 || done_seen != 1) begin
            tests_failed++;
            $display("FAIL midrun_complete: pairs %0d done %0d expected 1 and 1", got_q.size(), done_seen);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        op_ready = 1'b0;
        pulse_start(8'd10);
        for (int i = 0; i < 150 && m_state != M_IDLE; i++) begin
            op_ready = i[0];
            lfsr_in  = WIDTH'($urandom);
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL wrap_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (got_q.size() != 10 || got_q != pushed_q || done_seen != 1) begin
            tests_failed++;
            $display("FAIL wrap_order: pairs %0d done %0d expected 10 in order and 1", got_q.size(), done_seen);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            clear_logs();
            op_ready = 1'($urandom);
            pulse_start(8'($urandom_range(0, 12)));
            for (int i = 0; i < 400 && m_state != M_IDLE; i++) begin
                lfsr_in   = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
                op_ready  = 1'($urandom);
                start     = ($urandom_range(0, 5) == 0);
                num_pairs = 8'($urandom);
                step();
                tests_run++;
                if (obs_vec() !== exp_vec()) begin
                    tests_failed++;
                    $display("FAIL rand%0d_cycle%0d: got %h expected %h", r, i, obs_vec(), exp_vec());
                end
            end
            start = 1'b0;
            tests_run++;
            if (got_q != pushed_q || done_seen != 1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand%0d_end: pairs %0d of %0d done %0d busy %b",
                         r, got_q.size(), pushed_q.size(), done_seen, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_lock();
        test_backpressure();
        test_reset_midrun();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
